mic_fir_coeff_ctrl: RTL and testbench

Double-banked coefficient store and controller for the mic-array FIR, supporting glitch-free coefficient updates. The host (wishbone bridge) writes a shadow bank while the FIR reads the active bank. On commit, the banks swap only between FIR tap loops, then the new active set is copied back into the shadow. The block arbitrates the active bank's single read port between FIR tap fetches and the copy engine.

---
 rtl/mic_fir_coeff_ctrl_if.sv | 28 ++
 rtl/mic_fir_coeff_ctrl.sv | 133 +++++++++++++
 tb/tb_mic_fir_coeff_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_fir_coeff_ctrl_if.sv
// Host shadow-bank access, commit control and FIR coefficient fetch signals.
interface mic_fir_coeff_ctrl_if #(
    parameter int FIR_TAP_WIDTH = 16,
    parameter int FIR_TAP_ADDR  = 7
);
    logic                     host_we;
    logic                     host_re;
    logic [FIR_TAP_ADDR-1:0]  host_addr;
    logic [FIR_TAP_WIDTH-1:0] host_wdata;
    logic [FIR_TAP_WIDTH-1:0] host_rdata;
    logic                     host_ack;
    logic                     commit_req;
    logic                     busy;
    logic                     active_bank;
    logic                     fir_busy;
    logic [FIR_TAP_ADDR-1:0]  coeff_addr;
    logic [FIR_TAP_WIDTH-1:0] coeff_data;

    modport master (
        output host_we, host_re, host_addr, host_wdata, commit_req, fir_busy, coeff_addr,
        input  host_rdata, host_ack, busy, active_bank, coeff_data
    );

    modport slave (
        input  host_we, host_re, host_addr, host_wdata, commit_req, fir_busy, coeff_addr,
        output host_rdata, host_ack, busy, active_bank, coeff_data
    );
endinterface

// File: rtl/mic_fir_coeff_ctrl.sv
// Double-banked FIR coefficient store: host writes shadow, FIR reads active, commit swaps then copies back.
// 1-cycle read/ack latency; host gets no ack while a commit is pending or the copy-back runs.
module mic_fir_coeff_ctrl #(
    parameter int FIR_TAP_WIDTH = 16,
    parameter int FIR_TAP       = 128,
    parameter int FIR_TAP_ADDR  = 7
) (
    input  logic                 clk,
    input  logic                 resetn,
    mic_fir_coeff_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PEND, COPY} state_e;

    localparam logic [FIR_TAP_ADDR-1:0] LAST_TAP = FIR_TAP_ADDR'(FIR_TAP - 1);

    logic [FIR_TAP_WIDTH-1:0] bank_mem [2][FIR_TAP];

    state_e                   state_q, state_d;
    logic                     active_bank_q, active_bank_d;
    logic [FIR_TAP_ADDR-1:0]  cnt_q, cnt_d;
    logic                     rd_done_q, rd_done_d;
    logic                     cp_wr_vld_q, cp_wr_vld_d;
    logic [FIR_TAP_ADDR-1:0]  cp_wr_addr_q, cp_wr_addr_d;
    logic [FIR_TAP_WIDTH-1:0] coeff_data_q, coeff_data_d;
    logic [FIR_TAP_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                     host_ack_q, host_ack_d;

    logic                     shadow;
    logic [FIR_TAP_ADDR-1:0]  rd_addr;
    logic                     mem_we;
    logic [FIR_TAP_ADDR-1:0]  mem_waddr;
    logic [FIR_TAP_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        cnt_d         = cnt_q;
        rd_done_d     = rd_done_q;
        cp_wr_vld_d   = 1'b0;
        cp_wr_addr_d  = cp_wr_addr_q;
        host_rdata_d  = host_rdata_q;
        host_ack_d    = 1'b0;
        shadow        = ~active_bank_q;
        rd_addr       = bus.coeff_addr;
        mem_we        = 1'b0;
        mem_waddr     = bus.host_addr;
        mem_wdata     = bus.host_wdata;

        case (state_q)
            IDLE: begin
                if (bus.host_we) begin
                    mem_we     = 1'b1;
                    host_ack_d = 1'b1;
                end else if (bus.host_re) begin
                    host_rdata_d = bank_mem[shadow][bus.host_addr];
                    host_ack_d   = 1'b1;
                end
                if (bus.commit_req) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // Swap only in a gap between FIR tap loops.
                if (!bus.fir_busy) begin
                    active_bank_d = ~active_bank_q;
                    state_d       = COPY;
                    cnt_d         = '0;
                    rd_done_d     = 1'b0;
                end
            end
            COPY: begin
                if (!bus.fir_busy && !rd_done_q) begin
                    rd_addr      = cnt_q;
                    cp_wr_vld_d  = 1'b1;
                    cp_wr_addr_d = cnt_q;
                    if (cnt_q == LAST_TAP) begin
                        rd_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Write-back uses the registered read, so a FIR fetch this cycle cannot corrupt it.
                if (cp_wr_vld_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = cp_wr_addr_q;
                    mem_wdata = coeff_data_q;
                    if (cp_wr_addr_q == LAST_TAP) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        coeff_data_d = bank_mem[active_bank_q][rd_addr];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            bank_mem[~active_bank_q][mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            active_bank_q <= 1'b0;
            cnt_q         <= '0;
            rd_done_q     <= 1'b0;
            cp_wr_vld_q   <= 1'b0;
            cp_wr_addr_q  <= '0;
            coeff_data_q  <= '0;
            host_rdata_q  <= '0;
            host_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            cnt_q         <= cnt_d;
            rd_done_q     <= rd_done_d;
            cp_wr_vld_q   <= cp_wr_vld_d;
            cp_wr_addr_q  <= cp_wr_addr_d;
            coeff_data_q  <= coeff_data_d;
            host_rdata_q  <= host_rdata_d;
            host_ack_q    <= host_ack_d;
        end
    end

    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.active_bank = active_bank_q;
    assign bus.coeff_data  = coeff_data_q;
endmodule

// File: tb/tb_mic_fir_coeff_ctrl.sv
// Bench for mic_fir_coeff_ctrl: directed scenarios plus random traffic against a bank-level model.
module tb_mic_fir_coeff_ctrl;
    localparam int W = 16;
    localparam int N = 128;
    localparam int A = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mic_fir_coeff_ctrl_if #(.FIR_TAP_WIDTH(W), .FIR_TAP_ADDR(A)) bus ();

    mic_fir_coeff_ctrl #(.FIR_TAP_WIDTH(W), .FIR_TAP(N), .FIR_TAP_ADDR(A)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: two banks with per-entry known flags, and the copy as a count of taps issued.
    logic [W-1:0] mb [2][N];
    bit           mk [2][N];
    bit           m_act, m_pend, m_copy, m_idle;
    int           m_issued, m_lastrd, m_wr, m_a;
    logic [W-1:0] e_rdata, e_coeff;
    bit           e_rdata_k, e_coeff_k, e_coeff_chk, e_ack;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act = 0; m_pend = 0; m_copy = 0; m_issued = 0; m_lastrd = -1;
            e_ack = 0; e_rdata = '0; e_rdata_k = 1; e_coeff = '0; e_coeff_k = 1; e_coeff_chk = 1;
        end else begin
            m_idle      = !m_pend && !m_copy;
            m_a         = int'(bus.coeff_addr);
            e_coeff_chk = bus.fir_busy || !m_copy;
            e_coeff     = mb[m_act][m_a];
            e_coeff_k   = mk[m_act][m_a];
            m_wr        = m_lastrd;
            m_lastrd    = -1;
            if (m_copy && !bus.fir_busy && m_issued < N) begin
                m_lastrd = m_issued;
                m_issued++;
            end
            if (m_wr >= 0) begin
                mb[!m_act][m_wr] = mb[m_act][m_wr];
                mk[!m_act][m_wr] = mk[m_act][m_wr];
                if (m_wr == N - 1) m_copy = 0;
            end
            e_ack = 0;
            if (m_idle && bus.host_we) begin
                mb[!m_act][int'(bus.host_addr)] = bus.host_wdata;
                mk[!m_act][int'(bus.host_addr)] = 1;
                e_ack = 1;
            end else if (m_idle && bus.host_re) begin
                e_rdata   = mb[!m_act][int'(bus.host_addr)];
                e_rdata_k = mk[!m_act][int'(bus.host_addr)];
                e_ack     = 1;
            end
            if (m_pend && !bus.fir_busy) begin
                m_act = !m_act; m_pend = 0; m_copy = 1; m_issued = 0;
            end else if (m_idle && bus.commit_req) begin
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("active_bank", 32'(bus.active_bank), 32'(m_act));
            chk("busy", 32'(bus.busy), 32'(m_pend || m_copy));
            chk("host_ack", 32'(bus.host_ack), 32'(e_ack));
            if (e_rdata_k) chk("host_rdata", 32'(bus.host_rdata), 32'(e_rdata));
            if (e_coeff_chk && e_coeff_k) chk("coeff_data", 32'(bus.coeff_data), 32'(e_coeff));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [W-1:0] d, output int cyc);
        bus.host_we = 1'b1; bus.host_addr = A'(addr); bus.host_wdata = d; cyc = 0;
        do begin step(); cyc++; end while (!bus.host_ack && cyc < 1000);
        bus.host_we = 1'b0;
        chk("wr_ack_seen", 32'(bus.host_ack), 32'd1);
    endtask

    task automatic host_read(input int addr, output logic [W-1:0] d, output int cyc);
        bus.host_re = 1'b1; bus.host_addr = A'(addr); cyc = 0;
        do begin step(); cyc++; end while (!bus.host_ack && cyc < 1000);
        bus.host_re = 1'b0;
        d = bus.host_rdata;
        chk("rd_ack_seen", 32'(bus.host_ack), 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 3000) begin step(); n++; end
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic commit_and_swap();
        bus.commit_req = 1'b1; step(); bus.commit_req = 1'b0;
        bus.fir_busy = 1'b0; step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_active"}, 32'(bus.active_bank), 32'd0);
        chk({tag, "_ack"}, 32'(bus.host_ack), 32'd0);
        chk({tag, "_coeff"}, 32'(bus.coeff_data), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.host_rdata), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n;
        logic [W-1:0] d;
        bit act0;
        bus.host_we = 0; bus.host_re = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.commit_req = 0; bus.fir_busy = 0; bus.coeff_addr = '0;
        repeat (3) step();
        chk_reset_outputs("por");
        resetn = 1'b1;
        step();

        // Basic host access and we-over-re priority.
        host_write(5, 16'h1234, c);  chk("wr_latency", c, 1);
        host_read(5, d, c);          chk("rd_latency", c, 1);
        chk("rd_data_5", 32'(d), 32'h1234);
        bus.host_we = 1; bus.host_re = 1; bus.host_addr = 6; bus.host_wdata = 16'hBEEF;
        step(); chk("both_ack_wr", 32'(bus.host_ack), 1);
        bus.host_we = 0;
        step(); chk("both_ack_rd", 32'(bus.host_ack), 1);
        chk("both_rdata", 32'(bus.host_rdata), 32'hBEEF);
        bus.host_re = 0;
        step();

        // Idle commit with shadow loaded as value=addr.
        for (int i = 0; i < N; i++) host_write(i, W'(i), c);
        bus.commit_req = 1; step(); bus.commit_req = 0;
        chk("pend_active", 32'(bus.active_bank), 0);
        chk("pend_busy", 32'(bus.busy), 1);
        step();
        chk("swap_active", 32'(bus.active_bank), 1);
        n = 0;
        while (bus.busy && n < 1000) begin step(); n++; end
        chk("copy_len", n, 129);
        bus.coeff_addr = 10; step();
        chk("coeff_10", 32'(bus.coeff_data), 10);
        host_read(10, d, c); chk("shadow_10", 32'(d), 10);

        // Commit during a 50-cycle tap loop must defer the swap.
        for (int i = 0; i < N; i++) host_write(i, W'($urandom), c);
        bus.fir_busy = 1;
        for (int k = 0; k < 50; k++) begin
            bus.coeff_addr = A'($urandom);
            bus.commit_req = (k == 3);
            step();
        end
        bus.commit_req = 0;
        chk("defer_active", 32'(bus.active_bank), 1);
        chk("defer_busy", 32'(bus.busy), 1);
        bus.fir_busy = 0; step();
        chk("defer_swap", 32'(bus.active_bank), 0);
        wait_idle(n);

        // Copy contended by a 4-on/4-off FIR pattern.
        for (int i = 0; i < 8; i++) host_write(int'($urandom_range(0, N - 1)), W'($urandom), c);
        commit_and_swap();
        n = 0;
        while (bus.busy && n < 2000) begin
            bus.fir_busy   = ((n / 4) % 2 == 0);
            bus.coeff_addr = A'($urandom);
            step(); n++;
        end
        bus.fir_busy = 0;
        chk("arb_copy_len", n, 257);
        for (int i = 0; i < N; i++) begin
            host_read(i, d, c);
            chk("shadow_eq_active", 32'(d), 32'(mb[m_act][i]));
        end

        // Host write and extra commits while pending/copying.
        act0 = bus.active_bank;
        bus.fir_busy = 1; bus.commit_req = 1; step(); bus.commit_req = 0;
        bus.host_we = 1; bus.host_addr = 20; bus.host_wdata = 16'h5A5A;
        for (int k = 0; k < 10; k++) begin
            bus.commit_req = (k == 4);
            step();
            chk("stall_pend_ack", 32'(bus.host_ack), 0);
        end
        bus.commit_req = 0; bus.fir_busy = 0; step();
        chk("stall_swap", 32'(bus.active_bank), 32'(!act0));
        bus.commit_req = 1; step(); bus.commit_req = 0;
        n = 0;
        while (!bus.host_ack && n < 1000) begin step(); n++; end
        bus.host_we = 0;
        chk("stall_ack_after_idle", 32'(bus.host_ack), 1);
        repeat (5) step();
        chk("single_swap", 32'(bus.active_bank), 32'(!act0));
        chk("single_swap_busy", 32'(bus.busy), 0);
        host_read(20, d, c); chk("stall_wr_landed", 32'(d), 32'h5A5A);

        // Random traffic.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                host_write(int'($urandom_range(0, N - 1)), W'($urandom), c);
            for (int i = 0; i < 2; i++) host_read(int'($urandom_range(0, N - 1)), d, c);
            bus.commit_req = 1; step(); bus.commit_req = 0;
            n = 0;
            while (bus.busy && n < 3000) begin
                bus.fir_busy   = 1'($urandom_range(0, 1));
                bus.coeff_addr = A'($urandom);
                step(); n++;
            end
            bus.fir_busy = 0;
            chk("rand_idle", 32'(bus.busy), 0);
        end

        // Reset in the middle of a copy.
        commit_and_swap();
        repeat (20) step();
        resetn = 0; #1;
        chk_reset_outputs("midcopy_rst");
        step();
        resetn = 1;
        step();
        host_write(7, 16'h0777, c); chk("post_rst_wr_lat", c, 1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
